// File: rtl/load_writeback_unit_if.sv
// Purpose: request and data-bus signals of the load/writeback unit.
//   req_*  : load request from decode/execute (valid/ready handshake)
//   mem_*  : word-aligned read request to the data bus and its acknowledge/data
// Modports: slave = the load unit, master = the core/bus environment.
interface load_writeback_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd_address;
  logic        mem_read_valid;
  logic [31:0] mem_read_address;
  logic        mem_read_ack;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_address, req_funct3, req_rd_address, mem_read_ack, mem_read_data,
    output req_ready, mem_read_valid, mem_read_address
  );

  modport master (
    output req_valid, req_address, req_funct3, req_rd_address, mem_read_ack, mem_read_data,
    input  req_ready, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/load_writeback_unit.sv
// Purpose: executes RV32I loads (LB/LH/LW/LBU/LHU). Accepts one request, issues a
// word-aligned bus read, extracts/extends the addressed lane and strobes the result
// to the register file write port for one cycle.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   bus (slave)       : request handshake and data-bus read channel
//   rd, rd_address    : load result and destination index (hold between writes)
//   rd_write_enable   : one-cycle register file write strobe
//   load_error        : one-cycle pulse on misaligned/illegal request or bus timeout
//   busy              : high whenever a load is in flight
module load_writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  load_writeback_unit_if.slave   bus,
  output logic [31:0]            rd,
  output logic [4:0]             rd_address,
  output logic                   rd_write_enable,
  output logic                   load_error,
  output logic                   busy
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [REG_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_valid_q, mem_valid_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [REG_IDX_W-1:0] rd_address_q, rd_address_d;
  logic                rd_we_q, rd_we_d;
  logic                load_error_q, load_error_d;
  logic                req_illegal;
  logic                timeout;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_ext;

  // Request legality: unknown funct3 or misaligned half/word access.
  always_comb begin
    req_illegal = 1'b0;
    case (bus.req_funct3)
      F3_LB, F3_LBU: req_illegal = 1'b0;
      F3_LH, F3_LHU: req_illegal = bus.req_address[0];
      F3_LW:         req_illegal = |bus.req_address[1:0];
      default:       req_illegal = 1'b1;
    endcase
  end

  // Lane extraction and extension of the returned word.
  assign byte_sel = bus.mem_read_data[{addr_lo_q, 3'b000} +: 8];
  assign half_sel = bus.mem_read_data[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.mem_read_data;
    case (funct3_q)
      F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_ext = {24'h000000, byte_sel};
      F3_LHU:  load_ext = {16'h0000, half_sel};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  // Timeout fires on the edge where the READ cycle count reaches MEM_TIMEOUT.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_W'(MEM_TIMEOUT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    rd_idx_d     = rd_idx_q;
    mem_addr_d   = mem_addr_q;
    rd_d         = rd_q;
    rd_address_d = rd_address_q;
    rd_we_d      = 1'b0;
    load_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          if (req_illegal) begin
            load_error_d = 1'b1;
          end else begin
            state_d    = READ;
            cnt_d      = '0;
            addr_lo_d  = bus.req_address[1:0];
            funct3_d   = bus.req_funct3;
            rd_idx_d   = bus.req_rd_address;
            mem_addr_d = {bus.req_address[31:2], 2'b00};
          end
        end
      end
      READ: begin
        // Ack takes priority over a coincident timeout.
        if (bus.mem_read_ack) begin
          state_d      = WRITE;
          rd_d         = load_ext;
          rd_address_d = rd_idx_q;
          rd_we_d      = (rd_idx_q != '0);
        end else if (timeout) begin
          state_d      = IDLE;
          load_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_valid_d = (state_d == READ);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      funct3_q     <= '0;
      rd_idx_q     <= '0;
      mem_addr_q   <= '0;
      mem_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rd_q         <= '0;
      rd_address_q <= '0;
      rd_we_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      rd_idx_q     <= rd_idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_valid_q  <= mem_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      rd_q         <= rd_d;
      rd_address_q <= rd_address_d;
      rd_we_q      <= rd_we_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.mem_read_valid   = mem_valid_q;
  assign bus.mem_read_address = mem_addr_q;
  assign rd                   = rd_q;
  assign rd_address           = rd_address_q;
  assign rd_write_enable      = rd_we_q;
  assign load_error           = load_error_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Purpose: randomized + directed bench for load_writeback_unit against a
// transaction-level reference model of RV32I load semantics.
module tb_load_writeback_unit;
  localparam int unsigned TO = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rd;
  logic [4:0]  rd_address;
  logic        rd_write_enable;
  logic        load_error;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rd      = '0;
  logic [4:0]  last_rd_addr = '0;

  always #5 clock = ~clock;

  load_writeback_unit_if bus_if ();

  load_writeback_unit #(.MEM_TIMEOUT(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus_if),
    .rd              (rd),
    .rd_address      (rd_address),
    .rd_write_enable (rd_write_enable),
    .load_error      (load_error),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit ref_legal(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    h = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (f)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return d;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_quiet_idle(input string tag);
    check({tag, "_we"},    rd_write_enable, 1'b0);
    check({tag, "_err"},   load_error, 1'b0);
    check({tag, "_valid"}, bus_if.mem_read_valid, 1'b0);
    check({tag, "_ready"}, bus_if.req_ready, 1'b1);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_rd"},    rd, last_rd);
    check({tag, "_rdadr"}, rd_address, last_rd_addr);
  endtask

  // One full load transaction; ack given after wait_n stall cycles in READ.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rdi,
                         input int wait_n, input logic [31:0] data);
    bit          ok;
    logic [31:0] exp;
    ok  = ref_legal(addr, f3);
    exp = ref_load(addr, f3, data);
    @(negedge clock);
    check("accept_ready", bus_if.req_ready, 1'b1);
    bus_if.req_valid      = 1'b1;
    bus_if.req_address    = addr;
    bus_if.req_funct3     = f3;
    bus_if.req_rd_address = rdi;
    @(negedge clock);
    bus_if.req_valid = 1'b0;
    if (!ok) begin
      check("illegal_err",   load_error, 1'b1);
      check("illegal_valid", bus_if.mem_read_valid, 1'b0);
      check("illegal_we",    rd_write_enable, 1'b0);
      check("illegal_rd",    rd, last_rd);
      @(negedge clock);
      check_quiet_idle("illegal_after");
      return;
    end
    for (int i = 0; i <= wait_n; i++) begin
      check("read_valid", bus_if.mem_read_valid, 1'b1);
      check("read_addr",  bus_if.mem_read_address, {addr[31:2], 2'b00});
      check("read_ready", bus_if.req_ready, 1'b0);
      check("read_busy",  busy, 1'b1);
      check("read_err",   load_error, 1'b0);
      check("read_we",    rd_write_enable, 1'b0);
      // Requests offered while busy must be ignored.
      bus_if.req_valid   = 1'($urandom);
      bus_if.req_address = $urandom;
      bus_if.req_funct3  = 3'($urandom);
      bus_if.mem_read_ack  = (i == wait_n);
      bus_if.mem_read_data = (i == wait_n) ? data : $urandom;
      @(negedge clock);
      bus_if.mem_read_ack  = 1'b0;
      bus_if.mem_read_data = $urandom;
      if (i != wait_n && i == int'(TO) - 1) begin
        check("to_err",   load_error, 1'b1);
        check("to_we",    rd_write_enable, 1'b0);
        check("to_valid", bus_if.mem_read_valid, 1'b0);
        check("to_ready", bus_if.req_ready, 1'b1);
        check("to_busy",  busy, 1'b0);
        bus_if.req_valid    = 1'b0;
        bus_if.mem_read_ack = 1'b1;
        @(negedge clock);
        bus_if.mem_read_ack = 1'b0;
        check_quiet_idle("late_ack");
        return;
      end
    end
    check("wr_we",    rd_write_enable, (rdi != 5'd0));
    check("wr_rd",    rd, exp);
    check("wr_rdadr", rd_address, rdi);
    check("wr_err",   load_error, 1'b0);
    check("wr_ready", bus_if.req_ready, 1'b0);
    check("wr_valid", bus_if.mem_read_valid, 1'b0);
    last_rd      = exp;
    last_rd_addr = rdi;
    @(negedge clock);
    check_quiet_idle("post_wr");
    bus_if.req_valid = 1'b0;
  endtask

  initial begin
    bus_if.req_valid      = 1'b0;
    bus_if.req_address    = '0;
    bus_if.req_funct3     = '0;
    bus_if.req_rd_address = '0;
    bus_if.mem_read_ack   = 1'b0;
    bus_if.mem_read_data  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_quiet_idle("reset");
    check("reset_maddr", bus_if.mem_read_address, 32'h0);
    reset = 1'b1;

    do_load(32'h0000_1003, 3'b000, 5'd7,  0, 32'h80FF_1234);
    do_load(32'h0000_2002, 3'b101, 5'd9,  5, 32'hBEEF_0001);
    do_load(32'h0000_2002, 3'b001, 5'd10, 5, 32'hBEEF_0001);
    do_load(32'h0000_3002, 3'b010, 5'd3,  0, $urandom);
    do_load(32'h0000_3000, 3'b011, 5'd3,  0, $urandom);
    do_load(32'h0000_5000, 3'b010, 5'd4,  int'(TO) + 3, $urandom);
    do_load(32'h0000_5004, 3'b010, 5'd4,  int'(TO) - 1, 32'hCAFE_F00D);

    // Reset while a read is outstanding; the following ack must be dropped.
    @(negedge clock);
    bus_if.req_valid      = 1'b1;
    bus_if.req_address    = 32'h0000_6000;
    bus_if.req_funct3     = 3'b010;
    bus_if.req_rd_address = 5'd5;
    @(negedge clock);
    bus_if.req_valid = 1'b0;
    check("rst_pre_valid", bus_if.mem_read_valid, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    last_rd      = '0;
    last_rd_addr = '0;
    check_quiet_idle("rst_abort");
    reset = 1'b1;
    bus_if.mem_read_ack  = 1'b1;
    bus_if.mem_read_data = 32'h1234_5678;
    @(negedge clock);
    bus_if.mem_read_ack = 1'b0;
    check_quiet_idle("rst_late_ack");

    do_load(32'h0000_4000, 3'b010, 5'd0, 2, 32'hDEAD_BEEF);

    for (int n = 0; n < 40; n++) begin
      do_load($urandom, 3'($urandom), 5'($urandom), int'($urandom_range(0, 8)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
